io_load_sequencer: RTL and testbench

//  Sequences the chip's initial load: streams words from the shared input bus into CNNRam, FCRam
//  and the image RAM, in order CNN weights -> FC weights -> image.

---
 rtl/io_load_pkg.sv | 26 ++
 rtl/io_load_sequencer_counter.sv | 43 ++++
 rtl/io_load_sequencer.sv | 175 +++++++++++++++++
 tb/tb_io_load_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/io_load_pkg.sv
// Shared state encodings, RAM-select codes and default word counts for the
// chip initial-load sequencer.
package io_load_pkg;

    typedef logic [2:0] load_state_t;

    localparam load_state_t ST_IDLE     = 3'd0;
    localparam load_state_t ST_LOAD_CNN = 3'd1;
    localparam load_state_t ST_LOAD_FC  = 3'd2;
    localparam load_state_t ST_LOAD_IMG = 3'd3;
    localparam load_state_t ST_DONE     = 3'd4;

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_CNN  = 3'b001;
    localparam logic [2:0] SEL_FC   = 3'b010;
    localparam logic [2:0] SEL_IMG  = 3'b100;

    localparam int DEF_CNN_WORDS = 1024;
    localparam int DEF_FC_WORDS  = 4096;
    localparam int DEF_IMG_WORDS = 1024;

    function automatic logic is_load_state(input load_state_t s);
        return (s == ST_LOAD_CNN) || (s == ST_LOAD_FC) || (s == ST_LOAD_IMG);
    endfunction

endpackage

// File: rtl/io_load_sequencer_counter.sv
// Per-phase word counter: counts accepted words and wraps to zero on the
// final word of the current phase so every RAM starts at address 0.
module load_word_counter #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [ADDR_W:0]   limit,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] count_d;

    // next-count and end-of-phase detect
    always_comb begin
        last    = inc & ({1'b0, count_q} == (limit - ONE));
        count_d = count_q;
        if (last) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/io_load_sequencer.sv
// Initial-load sequencer: streams input words into CNN, FC and image RAMs
// in that order over a shared registered write port, with sticky done flags.
module io_load_sequencer
    import io_load_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 13,
    parameter int CNN_WORDS = DEF_CNN_WORDS,
    parameter int FC_WORDS  = DEF_FC_WORDS,
    parameter int IMG_WORDS = DEF_IMG_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [2:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              doneLoadingCNN,
    output logic              doneLoadingFC,
    output logic              doneLoadingIMG,
    output logic              busy
);

    if (CNN_WORDS < 1 || CNN_WORDS > 2**ADDR_W) begin : g_bad_cnn
        $error("io_load_sequencer: CNN_WORDS out of range for ADDR_W");
    end
    if (FC_WORDS < 1 || FC_WORDS > 2**ADDR_W) begin : g_bad_fc
        $error("io_load_sequencer: FC_WORDS out of range for ADDR_W");
    end
    if (IMG_WORDS < 1 || IMG_WORDS > 2**ADDR_W) begin : g_bad_img
        $error("io_load_sequencer: IMG_WORDS out of range for ADDR_W");
    end

    localparam logic [ADDR_W:0] CNN_LIM = (ADDR_W+1)'(CNN_WORDS);
    localparam logic [ADDR_W:0] FC_LIM  = (ADDR_W+1)'(FC_WORDS);
    localparam logic [ADDR_W:0] IMG_LIM = (ADDR_W+1)'(IMG_WORDS);

    load_state_t       state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [2:0]        wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_cnn_q, done_cnn_d;
    logic              done_fc_q, done_fc_d;
    logic              done_img_q, done_img_d;

    logic              accept_s;
    logic              last_s;
    logic [ADDR_W-1:0] count_s;
    logic [ADDR_W:0]   limit_s;
    logic [2:0]        phase_sel_s;

    load_word_counter #(.ADDR_W(ADDR_W)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept_s),
        .limit (limit_s),
        .count (count_s),
        .last  (last_s)
    );

    // phase decode, FSM next state, done flags and write-port next values
    always_comb begin
        in_ready    = is_load_state(state_q);
        busy        = is_load_state(state_q);
        accept_s    = in_valid & in_ready;
        state_d     = state_q;
        done_cnn_d  = done_cnn_q;
        done_fc_d   = done_fc_q;
        done_img_d  = done_img_q;
        limit_s     = CNN_LIM;
        phase_sel_s = SEL_NONE;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d    = ST_LOAD_CNN;
                    done_cnn_d = 1'b0;
                    done_fc_d  = 1'b0;
                    done_img_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD_CNN: begin
                limit_s     = CNN_LIM;
                phase_sel_s = SEL_CNN;
                if (last_s) begin
                    state_d    = ST_LOAD_FC;
                    done_cnn_d = 1'b1;
                end else begin
                    state_d = ST_LOAD_CNN;
                end
            end
            ST_LOAD_FC: begin
                limit_s     = FC_LIM;
                phase_sel_s = SEL_FC;
                if (last_s) begin
                    state_d   = ST_LOAD_IMG;
                    done_fc_d = 1'b1;
                end else begin
                    state_d = ST_LOAD_FC;
                end
            end
            ST_LOAD_IMG: begin
                limit_s     = IMG_LIM;
                phase_sel_s = SEL_IMG;
                if (last_s) begin
                    state_d    = ST_DONE;
                    done_img_d = 1'b1;
                end else begin
                    state_d = ST_LOAD_IMG;
                end
            end
            ST_DONE: begin
                // load must drop before another sequence can start
                if (!load) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_en_d = accept_s;
        if (accept_s) begin
            wr_sel_d  = phase_sel_s;
            wr_addr_d = count_s;
            wr_data_d = in_data;
        end else begin
            wr_sel_d  = wr_sel_q;
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end
    end

    // state, write port and done flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= SEL_NONE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_cnn_q <= 1'b0;
            done_fc_q  <= 1'b0;
            done_img_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_cnn_q <= done_cnn_d;
            done_fc_q  <= done_fc_d;
            done_img_q <= done_img_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_sel         = wr_sel_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign doneLoadingCNN = done_cnn_q;
    assign doneLoadingFC  = done_fc_q;
    assign doneLoadingIMG = done_img_q;

endmodule

// File: tb/tb_io_load_sequencer.sv
// Directed bench for io_load_sequencer with 4/3/2-word CNN/FC/IMG phases.
module tb_io_load_sequencer;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wr_en;
    logic [2:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              done_cnn, done_fc, done_img;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int acc;

    io_load_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .CNN_WORDS(4), .FC_WORDS(3), .IMG_WORDS(2)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .doneLoadingCNN(done_cnn), .doneLoadingFC(done_fc),
        .doneLoadingIMG(done_img), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // expected write target for the n-th accepted word (0-based) in one sequence
    function automatic logic [2:0] exp_sel(input int n);
        if (n < 4) return 3'b001;
        else if (n < 7) return 3'b010;
        else return 3'b100;
    endfunction

    function automatic logic [31:0] exp_addr(input int n);
        if (n < 4) return 32'(n);
        else if (n < 7) return 32'(n - 4);
        else return 32'(n - 7);
    endfunction

    task automatic chk_write(input string tag, input int n, input logic [31:0] data);
        chk({tag, ".wr_en"}, {31'd0, wr_en}, 32'd1);
        chk({tag, ".wr_sel"}, {29'd0, wr_sel}, {29'd0, exp_sel(n)});
        chk({tag, ".wr_addr"}, {19'd0, wr_addr}, exp_addr(n));
        chk({tag, ".wr_data"}, {16'd0, wr_data}, data);
    endtask

    // flags expected after `count` accepts of the current sequence have been written
    task automatic chk_flags(input string tag, input int count);
        chk({tag, ".cnn"}, {31'd0, done_cnn}, {31'd0, count >= 4});
        chk({tag, ".fc"},  {31'd0, done_fc},  {31'd0, count >= 7});
        chk({tag, ".img"}, {31'd0, done_img}, {31'd0, count >= 9});
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; in_valid = 1'b1; in_data = 16'h0077;

        // 1: reset with load/in_valid asserted
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst.wr_en", {31'd0, wr_en}, 32'd0);
            chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst.busy", {31'd0, busy}, 32'd0);
            chk("rst.wr_sel", {29'd0, wr_sel}, 32'd0);
            chk("rst.wr_addr", {19'd0, wr_addr}, 32'd0);
            chk("rst.wr_data", {16'd0, wr_data}, 32'd0);
            chk_flags("rst.flags", 0);
        end
        rst = 1'b0;
        cyc();
        chk("start.in_ready", {31'd0, in_ready}, 32'd1);
        chk("start.busy", {31'd0, busy}, 32'd1);
        chk("start.wr_en", {31'd0, wr_en}, 32'd0);

        // 2: back-to-back stream of 9 words
        for (int k = 0; k < 9; k++) begin
            in_data = 16'h0010 + 16'(k);
            cyc();
            chk_write("stream", k, 32'h10 + 32'(k));
            chk_flags("stream.flags", k + 1);
            chk("stream.in_ready", {31'd0, in_ready}, {31'd0, k != 8});
            chk("stream.busy", {31'd0, busy}, {31'd0, k != 8});
        end

        // 5: load held high in DONE -> nothing more happens
        in_data = 16'h0099;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold.wr_en", {31'd0, wr_en}, 32'd0);
            chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold.wr_sel", {29'd0, wr_sel}, 32'h4);
            chk("hold.wr_addr", {19'd0, wr_addr}, 32'd1);
            chk("hold.wr_data", {16'd0, wr_data}, 32'h18);
            chk_flags("hold.flags", 9);
        end
        load = 1'b0;
        cyc();
        chk("idle.busy", {31'd0, busy}, 32'd0);
        chk_flags("idle.flags", 9);
        load = 1'b1;
        cyc();
        chk_flags("reload.flags", 0);
        chk("reload.in_ready", {31'd0, in_ready}, 32'd1);

        // 3: in_valid alternating 1/0
        acc = 0;
        for (int j = 0; j < 18; j++) begin
            in_valid = (j % 2 == 0);
            in_data  = 16'h0020 + 16'(acc);
            cyc();
            if (j % 2 == 0) begin
                chk_write("gap", acc, 32'h20 + 32'(acc));
                acc++;
            end else begin
                chk("gap.wr_en", {31'd0, wr_en}, 32'd0);
            end
            chk_flags("gap.flags", acc);
            chk("gap.in_ready", {31'd0, in_ready}, {31'd0, acc < 9});
        end

        // 4: restart, reset after two FC writes
        in_valid = 1'b0;
        load = 1'b0;
        cyc();
        load = 1'b1;
        cyc();
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = 16'h0030 + 16'(k);
            cyc();
            chk_write("pre", k, 32'h30 + 32'(k));
        end
        chk_flags("pre.flags", 6);
        rst = 1'b1;
        in_data = 16'h00EE;
        cyc();
        chk("mid.wr_en", {31'd0, wr_en}, 32'd0);
        chk("mid.busy", {31'd0, busy}, 32'd0);
        chk("mid.in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid.wr_addr", {19'd0, wr_addr}, 32'd0);
        chk_flags("mid.flags", 0);
        rst = 1'b0;
        cyc();
        chk("mid.restart_ready", {31'd0, in_ready}, 32'd1);
        chk("mid.restart_wr_en", {31'd0, wr_en}, 32'd0);
        in_data = 16'h0040;
        cyc();
        chk_write("mid.first", 0, 32'h40);
        in_valid = 1'b0;

        // 6: in_valid in IDLE with load low is ignored
        rst = 1'b1;
        load = 1'b0;
        cyc();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h00AA;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle6.in_ready", {31'd0, in_ready}, 32'd0);
            chk("idle6.wr_en", {31'd0, wr_en}, 32'd0);
            chk("idle6.wr_data", {16'd0, wr_data}, 32'd0);
        end
        load = 1'b1;
        cyc();
        in_data = 16'h0055;
        cyc();
        chk_write("idle6.first", 0, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
